// File: rtl/img_pkg.sv
// Shared image-pipeline parameters and pixel/address types.
// Defaults here are the values every line_buffer instance uses unless overridden.
package img_pkg;
    localparam int LINE_WIDTH = 512;
    localparam int PIX_W      = 8;
    localparam int TAPS       = 3;

    typedef logic [PIX_W-1:0]              pix_t;
    typedef logic [$clog2(LINE_WIDTH)-1:0] line_addr_t;
endpackage

// File: rtl/line_buffer.sv
// Circular single-line pixel store presenting a TAPS-wide window at the read pointer.
// Latency: writes and read advances are visible on o_data right after their edge; no backpressure, caller paces.
// Backpressure: none -- no occupancy tracking, overwrite and read-ahead are legal.
module line_buffer
    import img_pkg::*;
#(
    parameter int LINE_WIDTH = img_pkg::LINE_WIDTH,
    parameter int PIX_W      = img_pkg::PIX_W,
    parameter int TAPS       = img_pkg::TAPS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PIX_W-1:0]      i_data,
    input  logic                  i_data_valid,
    output logic [TAPS*PIX_W-1:0] o_data,
    input  logic                  i_rd_data
);
    localparam int AW = $clog2(LINE_WIDTH);

    logic [PIX_W-1:0] mem [LINE_WIDTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is cleared on reset so the window never shows pre-reset pixels.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < LINE_WIDTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_data_valid) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_data_valid) wr_ptr <= wr_ptr + AW'(1);
            if (i_rd_data)    rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Tap 0 (oldest pixel) lands in the MSB byte; tap addresses wrap at line end.
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        logic [AW-1:0] tap_addr;
        assign tap_addr = rd_ptr + AW'(t);
        assign o_data[(TAPS-t)*PIX_W-1 -: PIX_W] = mem[tap_addr];
    end
endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer: reset, gated writes, read advance, wrap, simultaneous access, mid-stream reset.
module tb_line_buffer;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_data_valid = 1'b0;
    logic [23:0] o_data;
    logic        i_rd_data = 1'b0;

    int checks = 0;
    int passes = 0;

    line_buffer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data       (o_data),
        .i_rd_data    (i_rd_data)
    );

    always #5 i_clk = ~i_clk;

    // One clock with the given inputs; returns #1 after the rising edge with strobes idle.
    task automatic step(input logic [7:0] d, input logic vld, input logic rd);
        @(negedge i_clk);
        i_data       = d;
        i_data_valid = vld;
        i_rd_data    = rd;
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
        i_rd_data    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_data !== 24'h000000) $display("FAIL reset_in: o_data=%h expected=000000", o_data);
        else passes++;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_data !== 24'h000000) $display("FAIL reset_out: o_data=%h expected=000000", o_data);
        else passes++;
        checks++;
        if (dut.rd_ptr !== 9'd0) $display("FAIL reset_rd_ptr: rd_ptr=%0d expected=0", dut.rd_ptr);
        else passes++;
        checks++;
        if (dut.wr_ptr !== 9'd0) $display("FAIL reset_wr_ptr: wr_ptr=%0d expected=0", dut.wr_ptr);
        else passes++;
    endtask

    task automatic test_gated_write();
        do_reset();
        step(8'h1F, 1'b0, 1'b0);
        checks++;
        if (o_data !== 24'h000000) $display("FAIL gated_none: o_data=%h expected=000000", o_data);
        else passes++;
        step(8'h2F, 1'b1, 1'b0);
        checks++;
        if (o_data !== 24'h2F0000) $display("FAIL gated_first: o_data=%h expected=2F0000", o_data);
        else passes++;
        step(8'h3F, 1'b0, 1'b0);
        step(8'h4F, 1'b1, 1'b0);
        checks++;
        if (o_data !== 24'h2F4F00) $display("FAIL gated_final: o_data=%h expected=2F4F00", o_data);
        else passes++;
    endtask

    task automatic test_read_advance();
        do_reset();
        for (int i = 1; i <= 5; i++) step(8'(i), 1'b1, 1'b0);
        checks++;
        if (o_data !== 24'h010203) $display("FAIL read_initial: o_data=%h expected=010203", o_data);
        else passes++;
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if (o_data !== 24'h020304) $display("FAIL read_one: o_data=%h expected=020304", o_data);
        else passes++;
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if (o_data !== 24'h030405) $display("FAIL read_two: o_data=%h expected=030405", o_data);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [8:0] a;
        do_reset();
        // Reads ride along with the first 510 writes, leaving rd_ptr at 510.
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            step(a[7:0] + 8'd1, 1'b1, (i < 510) ? 1'b1 : 1'b0);
        end
        step(8'hAA, 1'b1, 1'b0);
        step(8'hBB, 1'b1, 1'b0);
        checks++;
        if (o_data !== 24'hFF00AA) $display("FAIL wrap_window: o_data=%h expected=FF00AA", o_data);
        else passes++;
        checks++;
        if (dut.wr_ptr !== 9'd2) $display("FAIL wrap_wr_ptr: wr_ptr=%0d expected=2", dut.wr_ptr);
        else passes++;
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if (o_data !== 24'h00AABB) $display("FAIL wrap_511: o_data=%h expected=00AABB", o_data);
        else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(8'h11, 1'b1, 1'b0);
        step(8'h22, 1'b1, 1'b0);
        step(8'h33, 1'b1, 1'b0);
        checks++;
        if (o_data !== 24'h112233) $display("FAIL simul_pre: o_data=%h expected=112233", o_data);
        else passes++;
        step(8'h77, 1'b1, 1'b1);
        checks++;
        if (o_data !== 24'h223377) $display("FAIL simul_post: o_data=%h expected=223377", o_data);
        else passes++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 10; i++) step(8'h10 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);
        checks++;
        if (o_data !== 24'h141516) $display("FAIL midrst_pre: o_data=%h expected=141516", o_data);
        else passes++;
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_data !== 24'h000000) $display("FAIL midrst_async: o_data=%h expected=000000", o_data);
        else passes++;
        @(negedge i_clk);
        i_rst = 1'b1;
        step(8'hC3, 1'b1, 1'b0);
        checks++;
        if (o_data !== 24'hC30000) $display("FAIL midrst_addr0: o_data=%h expected=C30000", o_data);
        else passes++;
        checks++;
        if (dut.wr_ptr !== 9'd1) $display("FAIL midrst_wr_ptr: wr_ptr=%0d expected=1", dut.wr_ptr);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_gated_write();
        test_read_advance();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
